regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Round-robin arbiter and sequencer that shares the 16-bit, 8-entry register file between NREQ independent requesters. It accepts one read or write command at a time and drives the register file's enable/write/select/data inputs as a stable multi-cycle command window. It then captures the register file's read output and returns a one-cycle response tagged with the requester index. It sits between the requesters, such as datapath sequencers and a debug port, and the single register file instance.

## Interface
- NREQ, default 4: number of requesters (2..8).
- DRIVE_CYCLES, default 3: cycles the command is held on the register file inputs with enable high (minimum 3).
- IDW, default $clog2(NREQ): width of the requester index.

Ports:
- aclk  in  1  clock; all logic is on its rising edge.
- areset  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_write  in  NREQ  per-requester: 1 = write, 0 = read.
- req_select  in  3*NREQ  per-requester register index; requester i uses bits [3i+2:3i].
- req_data  in  16*NREQ  per-requester write data; requester i uses bits [16i+15:16i].
- req_ready  out  NREQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  16  read data; 0 for writes.
- busy  out  1  high whenever state is not IDLE.
- rf_enable  out  1  to register file rx_enable.
- rf_write  out  1  to register file rx_write.
- rf_select  out  3  to register file rx_select.
- rf_data  out  16  to register file rx_data.
- rf_tx_data  in  16  from register file tx_data.

## Operation
- State machine has four states: IDLE, DRIVE, SETTLE, RESP.
- IDLE:
  - If any req_valid bit is set, pick the winner by round-robin.
  - Latch the winner's write, select and data fields and its index.
  - Go to DRIVE. Otherwise stay in IDLE.
- Round-robin pointer:
  - Search starts at the pointer and wraps modulo NREQ.
  - After a grant to requester w, the pointer becomes (w+1) mod NREQ.
  - Reset value of the pointer is 0.
- DRIVE:
  - rf_enable=1; rf_write, rf_select and rf_data come from the latched fields and are held constant.
  - req_ready[w]=1 in the first DRIVE cycle only.
  - A down-counter starts at DRIVE_CYCLES-1. When it reaches 0, go to SETTLE.
- SETTLE:
  - rf_enable=0; the rf_* fields keep their values.
  - On the closing edge, capture rsp_data: rf_tx_data for reads, 16'h0000 for writes.
  - A read of select 0 returns 16'h0000 regardless of rf_tx_data.
- RESP: rsp_valid=1 and rsp_id=w for one cycle, then go to IDLE.
- Requester rules:
  - Hold req_valid and the fields stable until req_ready is seen.
  - req_valid still high in the cycle after req_ready counts as a new command.
- Requests arriving in DRIVE, SETTLE or RESP wait. They are never dropped and never acknowledged early.
- Writes to select 0 are issued normally; the register file discards them.
- Reset: when areset is high at an edge, the next state is IDLE and all outputs, the pointer and the latches clear.
  - rsp_data=0, rsp_id=0, and rf_* all 0.
  - An in-flight command is abandoned: no rsp_valid, and no further req_ready.

## Timing
- Edge E0 in IDLE with req_valid set: the command is latched.
- Cycles E0+1 to E0+DRIVE_CYCLES: DRIVE; rf_enable high; req_ready in cycle E0+1.
- Cycle E0+DRIVE_CYCLES+1: SETTLE; rsp_data is registered at its closing edge.
- Cycle E0+DRIVE_CYCLES+2: RESP; rsp_valid high.
- Cycle E0+DRIVE_CYCLES+3: IDLE; the earliest possible next latch.
- Throughput is one command per DRIVE_CYCLES+3 cycles (6 at default). The gap between consecutive rf_enable windows is 3 cycles.
- rsp_data holds its value until the next SETTLE capture. rsp_id holds until the next RESP.
- All outputs are registered; there is no combinational path from req_* to any output.

## Test plan
- Single write then read: requester 1 writes select 5 with 16'hBEEF, then reads select 5. Required response:
  - req_ready[1] pulses in cycle 1 of each command.
  - Write response: rsp_valid with rsp_id=1, rsp_data=0.
  - Read response: rsp_id=1, rsp_data=16'hBEEF.
  - The two commands are spaced 6 cycles apart.
- Register 0: write 16'h1234 to select 0, then read select 0. The read returns rsp_data=16'h0000.
- Contention: all four req_valid high continuously from reset, each requester reading a distinct register. Required response:
  - Grant order is 0,1,2,3,0.
  - Exactly one req_ready bit is high at a time.
  - No requester waits more than 3 commands.
- Late arrival: requester 2 raises req_valid during requester 0's DRIVE. No req_ready[2] until requester 0's RESP is done; requester 2 is granted on the following IDLE edge.
- Reset mid-operation: assert areset in the second DRIVE cycle. Required response:
  - The next cycle has busy=0 and rf_enable=0.
  - No rsp_valid for that command.
  - The pointer is back to 0; after reset, requester 0 wins over requester 3 when both are valid.
- Stability: during every DRIVE/SETTLE window, rf_write, rf_select and rf_data never change, and rf_enable is high for exactly DRIVE_CYCLES cycles.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_if
// Requester-side bus of the register-file arbiter: NREQ packed command lanes
// plus the shared, tagged response.
//
//   req_valid  [NREQ]      per-requester command valid
//   req_write  [NREQ]      per-requester 1 = write, 0 = read
//   req_select [3*NREQ]    per-requester register index, lane i = [3i+2:3i]
//   req_data   [16*NREQ]   per-requester write data, lane i = [16i+15:16i]
//   req_ready  [NREQ]      one-hot, one-cycle accept pulse
//   rsp_valid              one-cycle response pulse
//   rsp_id     [IDW]       owner of the response
//   rsp_data   [16]        read data (0 for writes)
//
// master : the requester side (drives commands, sees ready/response)
// slave  : the arbiter
// -----------------------------------------------------------------------------
interface regfile_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [3*NREQ-1:0]  req_select;
    logic [16*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_data;

    modport master (
        output req_valid, req_write, req_select, req_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_select, req_data,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
// Round-robin arbiter/sequencer sharing one 16-bit x 8 register file between
// NREQ requesters. One command at a time is latched, held on the register
// file inputs for DRIVE_CYCLES cycles with enable high, followed by one
// settle cycle in which the read data is captured, then a one-cycle tagged
// response. All outputs are registered.
//
// Ports
//   aclk        clock, rising edge
//   areset      synchronous active-high reset
//   bus         requester bus (slave modport): req_* in, req_ready/rsp_* out
//   busy        high whenever the sequencer is not idle
//   rf_enable   register file rx_enable
//   rf_write    register file rx_write
//   rf_select   register file rx_select
//   rf_data     register file rx_data
//   rf_tx_data  register file tx_data (read return)
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int NREQ         = 4,
    parameter int DRIVE_CYCLES = 3,
    parameter int IDW          = $clog2(NREQ)
) (
    input  logic                aclk,
    input  logic                areset,
    regfile_arbiter_if.slave    bus,
    output logic                busy,
    output logic                rf_enable,
    output logic                rf_write,
    output logic [2:0]          rf_select,
    output logic [15:0]         rf_data,
    input  logic [15:0]         rf_tx_data
);
    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = $clog2(DRIVE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        RESP
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [IDW-1:0]      owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NREQ-1:0]     ready_q;
    logic                rsp_valid_q;
    logic [IDW-1:0]      rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                busy_q;
    logic                en_q;
    logic                wr_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   data_q;

    // Unpacked view of the per-requester lanes
    logic [SEL_W-1:0]    sel_lane  [NREQ];
    logic [DATA_W-1:0]   data_lane [NREQ];

    // Round-robin search result
    logic                win_found;
    logic [IDW-1:0]      win_idx;
    logic [IDW-1:0]      cand_idx;
    logic                win_write;
    logic [SEL_W-1:0]    win_sel;
    logic [DATA_W-1:0]   win_data;
    logic [IDW-1:0]      ptr_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            sel_lane[i]  = bus.req_select[SEL_W*i +: SEL_W];
            data_lane[i] = bus.req_data[DATA_W*i +: DATA_W];
        end
    end

    // Scan from the pointer upward, wrapping modulo NREQ; the first valid
    // requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        win_write = 1'b0;
        win_sel   = '0;
        win_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && bus.req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
                win_write = bus.req_write[cand_idx];
                win_sel   = sel_lane[cand_idx];
                win_data  = data_lane[cand_idx];
            end
        end
        ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            data_q      <= '0;
        end else begin
            // ready and rsp_valid are single-cycle pulses
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        owner_q <= win_idx;
                        ptr_q   <= ptr_d;
                        wr_q    <= win_write;
                        sel_q   <= win_sel;
                        data_q  <= win_data;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        ready_q <= NREQ'(1) << win_idx;
                        cnt_q   <= CNT_W'(DRIVE_CYCLES - 1);
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        state_q <= SETTLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    // Register 0 reads as zero whatever the file returns.
                    rsp_data_q  <= (wr_q || sel_q == '0) ? '0 : rf_tx_data;
                    rsp_id_q    <= owner_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = busy_q;
    assign rf_enable     = en_q;
    assign rf_write      = wr_q;
    assign rf_select     = sel_q;
    assign rf_data       = data_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
// Directed and randomized bench for regfile_arbiter. Requesters are modelled
// as per-requester command queues; the reference keeps a round-robin pointer
// and a shadow copy of the register contents, applied in grant order.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;
    localparam int NR = 4;
    localparam int DC = 3;
    localparam int IW = $clog2(NR);

    typedef struct packed {
        logic        wr;
        logic [2:0]  sel;
        logic [15:0] dat;
    } cmd_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic        busy;
    logic        rf_enable;
    logic        rf_write;
    logic [2:0]  rf_select;
    logic [15:0] rf_data;
    logic [15:0] rf_tx_data;

    regfile_arbiter_if #(.NREQ(NR)) bus ();

    regfile_arbiter #(.NREQ(NR), .DRIVE_CYCLES(DC)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .bus        (bus),
        .busy       (busy),
        .rf_enable  (rf_enable),
        .rf_write   (rf_write),
        .rf_select  (rf_select),
        .rf_data    (rf_data),
        .rf_tx_data (rf_tx_data)
    );

    always #5 aclk = ~aclk;

    // Register file stand-in; entry 0 keeps whatever is written so that the
    // arbiter has to zero it on read.
    logic [15:0] rf_mem [8] = '{default: 16'h0000};
    always @(posedge aclk) if (rf_enable && rf_write) rf_mem[rf_select] <= rf_data;
    assign rf_tx_data = rf_mem[rf_select];

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Reference state
    cmd_t        rq [NR][$];
    logic [15:0] shadow [8] = '{default: 16'h0000};
    int          ptr = 0;
    int          wait_cnt [NR] = '{default: 0};
    int          grant_log [$];
    int          ready_cyc [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                bus.req_valid[i]         = 1'b1;
                bus.req_write[i]         = rq[i][0].wr;
                bus.req_select[3*i +: 3] = rq[i][0].sel;
                bus.req_data[16*i +: 16] = rq[i][0].dat;
            end else begin
                bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (ptr + k) % NR;
            if (rq[i].size() > 0) return i;
        end
        return -1;
    endfunction

    // Runs one complete command from the IDLE cycle in which a request is
    // already presented. Optionally injects a late request in the second
    // DRIVE cycle, or resets during the second DRIVE cycle.
    task automatic issue(input int late_id, input cmd_t late_cmd, input bit reset_mid);
        int          w;
        int          wo;
        cmd_t        c;
        logic [15:0] exp_d;
        w = model_pick();
        if (w < 0) return;
        c = rq[w][0];
        step();
        chk("ready_onehot", 32'(bus.req_ready), 32'(1) << w);
        chk("busy_drive",   32'(busy), 1);
        chk("en_drive",     32'(rf_enable), 1);
        chk("rf_write",     32'(rf_write), 32'(c.wr));
        chk("rf_select",    32'(rf_select), 32'(c.sel));
        chk("rf_data",      32'(rf_data), 32'(c.dat));
        wo = -1;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) wo = i;
        grant_log.push_back(wo);
        ready_cyc.push_back(cyc);
        for (int i = 0; i < NR; i++) begin
            if (i != w && rq[i].size() > 0) begin
                wait_cnt[i]++;
                chk("wait_bound", 32'(wait_cnt[i] <= 3), 1);
            end
        end
        wait_cnt[w] = 0;
        ptr = (w + 1) % NR;
        void'(rq[w].pop_front());
        drive_bus();
        if (reset_mid) begin
            step();
            chk("en_drive2", 32'(rf_enable), 1);
            areset = 1'b1;
            step();
            areset = 1'b0;
            chk("rst_busy",     32'(busy), 0);
            chk("rst_en",       32'(rf_enable), 0);
            chk("rst_ready",    32'(bus.req_ready), 0);
            chk("rst_rspv",     32'(bus.rsp_valid), 0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 0);
            chk("rst_rsp_id",   32'(bus.rsp_id), 0);
            chk("rst_sel",      32'(rf_select), 0);
            chk("rst_data",     32'(rf_data), 0);
            ptr = 0;
            for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
            return;
        end
        for (int k = 2; k <= DC; k++) begin
            step();
            if (k == 2 && late_id >= 0) begin
                rq[late_id].push_back(late_cmd);
                drive_bus();
            end
            chk("ready_drive", 32'(bus.req_ready), 0);
            chk("en_drive",    32'(rf_enable), 1);
            chk("hold_write",  32'(rf_write), 32'(c.wr));
            chk("hold_select", 32'(rf_select), 32'(c.sel));
            chk("hold_data",   32'(rf_data), 32'(c.dat));
            chk("rspv_drive",  32'(bus.rsp_valid), 0);
        end
        step();
        chk("en_settle",     32'(rf_enable), 0);
        chk("busy_settle",   32'(busy), 1);
        chk("settle_write",  32'(rf_write), 32'(c.wr));
        chk("settle_select", 32'(rf_select), 32'(c.sel));
        chk("settle_data",   32'(rf_data), 32'(c.dat));
        chk("ready_settle",  32'(bus.req_ready), 0);
        chk("rspv_settle",   32'(bus.rsp_valid), 0);
        exp_d = (c.wr || c.sel == 3'd0) ? 16'h0000 : shadow[c.sel];
        if (c.wr) shadow[c.sel] = c.dat;
        step();
        chk("rsp_valid",  32'(bus.rsp_valid), 1);
        chk("rsp_id",     32'(bus.rsp_id), 32'(w));
        chk("rsp_data",   32'(bus.rsp_data), 32'(exp_d));
        chk("ready_resp", 32'(bus.req_ready), 0);
        step();
        chk("rspv_idle",      32'(bus.rsp_valid), 0);
        chk("busy_idle",      32'(busy), 0);
        chk("en_idle",        32'(rf_enable), 0);
        chk("ready_idle",     32'(bus.req_ready), 0);
        chk("rsp_data_hold",  32'(bus.rsp_data), 32'(exp_d));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (model_pick() >= 0 && guard < 200) begin
            issue(-1, '0, 1'b0);
            guard++;
        end
    endtask

    initial begin
        cmd_t c;
        cmd_t none;
        int   late;
        none = '0;
        areset         = 1'b1;
        bus.req_valid  = '0;
        bus.req_write  = '0;
        bus.req_select = '0;
        bus.req_data   = '0;
        repeat (3) step();
        chk("reset_busy",     32'(busy), 0);
        chk("reset_en",       32'(rf_enable), 0);
        chk("reset_ready",    32'(bus.req_ready), 0);
        chk("reset_rspv",     32'(bus.rsp_valid), 0);
        chk("reset_rsp_id",   32'(bus.rsp_id), 0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 0);
        chk("reset_sel",      32'(rf_select), 0);
        areset = 1'b0;
        step();

        // Requester 1: write BEEF to select 5, then read it back.
        rq[1].push_back('{1'b1, 3'd5, 16'hBEEF});
        rq[1].push_back('{1'b0, 3'd5, 16'h0000});
        drive_bus();
        ready_cyc.delete();
        drain();
        chk("wr_rd_spacing", 32'(ready_cyc[1] - ready_cyc[0]), 6);
        chk("wr_rd_readback", 32'(bus.rsp_data), 32'h0000_BEEF);

        // Register 0 always reads zero.
        rq[0].push_back('{1'b1, 3'd0, 16'h1234});
        rq[0].push_back('{1'b0, 3'd0, 16'h0000});
        drive_bus();
        drain();
        chk("reg0_read", 32'(bus.rsp_data), 0);

        // Late arrival of requester 2 during requester 0's DRIVE.
        rq[0].push_back('{1'b1, 3'd6, 16'hA5A5});
        drive_bus();
        grant_log.delete();
        issue(2, '{1'b0, 3'd6, 16'h0000}, 1'b0);
        issue(-1, none, 1'b0);
        chk("late_grant", 32'(grant_log[1]), 2);
        chk("late_data",  32'(bus.rsp_data), 32'h0000_A5A5);

        // Contention from reset: grant order 0,1,2,3,0.
        areset = 1'b1;
        step();
        areset = 1'b0;
        ptr = 0;
        rq[0].push_back('{1'b0, 3'd1, 16'h0});
        rq[0].push_back('{1'b0, 3'd1, 16'h0});
        rq[1].push_back('{1'b0, 3'd2, 16'h0});
        rq[2].push_back('{1'b0, 3'd3, 16'h0});
        rq[3].push_back('{1'b0, 3'd4, 16'h0});
        drive_bus();
        grant_log.delete();
        drain();
        chk("order0", 32'(grant_log[0]), 0);
        chk("order1", 32'(grant_log[1]), 1);
        chk("order2", 32'(grant_log[2]), 2);
        chk("order3", 32'(grant_log[3]), 3);
        chk("order4", 32'(grant_log[4]), 0);

        // Reset in the second DRIVE cycle of a requester-2 read (pointer
        // would otherwise favour requester 3 next).
        rq[2].push_back('{1'b0, 3'd5, 16'h0});
        drive_bus();
        issue(-1, none, 1'b1);
        repeat (4) begin
            step();
            chk("post_rst_rspv", 32'(bus.rsp_valid), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        rq[3].push_back('{1'b0, 3'd4, 16'h0});
        rq[0].push_back('{1'b0, 3'd1, 16'h0});
        drive_bus();
        grant_log.delete();
        drain();
        chk("post_rst_first",  32'(grant_log[0]), 0);
        chk("post_rst_second", 32'(grant_log[1]), 3);

        // Randomized traffic with occasional late arrivals.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
                        c.wr  = 1'($urandom_range(0, 1));
                        c.sel = 3'($urandom_range(0, 7));
                        c.dat = 16'($urandom);
                        rq[i].push_back(c);
                    end
                end
            end
            drive_bus();
            while (model_pick() >= 0) begin
                late = int'($urandom_range(0, NR - 1));
                c.wr  = 1'($urandom_range(0, 1));
                c.sel = 3'($urandom_range(0, 7));
                c.dat = 16'($urandom);
                if (rq[late].size() == 0 && $urandom_range(0, 1) == 1)
                    issue(late, c, 1'b0);
                else
                    issue(-1, none, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
